// File: rtl/operand_b_stage_pkg.sv
// Shared encodings for the operand-B stage: immediate extension modes and
// operand source tags reported alongside the registered operand.
package operand_b_stage_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10
    } ext_mode_e;

    localparam int unsigned SRC_RT   = 0;
    localparam int unsigned SRC_IMM  = 1;
    localparam int unsigned SRC_FWD0 = 2;

    // Width of the source tag: rt, imm and one code per forwarding source.
    function automatic int unsigned src_w(input int unsigned num_fwd);
        return $clog2(num_fwd + 2);
    endfunction

endpackage

// File: rtl/operand_b_stage_imm_extender.sv
// Combinational immediate extender: sign, zero or upper placement of a raw
// immediate into a WIDTH-bit operand. Encoding 2'b11 behaves as sign-extend.
module operand_b_stage_imm_extender
    import operand_b_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 16
) (
    input  logic [IMM_W-1:0] imm_i,
    input  logic [1:0]       ext_mode_i,
    output logic [WIDTH-1:0] ext_o
);

    if (WIDTH == IMM_W) begin : g_same_width
        // No room to extend: every mode passes the immediate through.
        logic [1:0] unused_mode;
        assign unused_mode = ext_mode_i;
        assign ext_o       = imm_i;
    end else begin : g_extend
        localparam int unsigned PadW = WIDTH - IMM_W;

        // Decode the extension mode into the padded operand.
        always_comb begin
            case (ext_mode_i)
                EXT_ZERO:  ext_o = {{PadW{1'b0}}, imm_i};
                EXT_UPPER: ext_o = {imm_i, {PadW{1'b0}}};
                default:   ext_o = {{PadW{imm_i[IMM_W-1]}}, imm_i};
            endcase
        end
    end

endmodule

// File: rtl/operand_b_stage.sv
// Operand-B select stage: chooses register, extended immediate or forwarded
// value and registers it towards EX behind a valid/ready handshake. A one-entry
// skid register absorbs EX back-pressure so in_ready is purely registered.
module operand_b_stage
    import operand_b_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned NUM_FWD = 2,
    localparam int unsigned SRC_W  = src_w(NUM_FWD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         rt_out_i,
    input  logic [IMM_W-1:0]         imm_i,
    input  logic [1:0]               ext_mode_i,
    input  logic                     sel_i,
    input  logic [NUM_FWD-1:0]       fwd_en_i,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_o,
    output logic [SRC_W-1:0]         out_src_o
);

    if (WIDTH < IMM_W) begin : g_width_check
        $error("operand_b_stage: WIDTH must be >= IMM_W");
    end

    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] sel_data;
    logic [SRC_W-1:0] sel_src;
    logic             accept;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [SRC_W-1:0] main_src_q,   main_src_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [SRC_W-1:0] skid_src_q,   skid_src_d;
    logic             in_ready_q,   in_ready_d;

    operand_b_stage_imm_extender #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_imm_extender (
        .imm_i      (imm_i),
        .ext_mode_i (ext_mode_i),
        .ext_o      (ext_imm)
    );

    // Operand select: immediate wins outright, else the lowest-index forward hit.
    always_comb begin
        sel_data = rt_out_i;
        sel_src  = SRC_W'(SRC_RT);
        if (sel_i) begin
            sel_data = ext_imm;
            sel_src  = SRC_W'(SRC_IMM);
        end else begin
            // Walk downwards so the lowest set index is written last.
            for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
                if (fwd_en_i[i]) begin
                    sel_data = fwd_data_i[i*int'(WIDTH) +: WIDTH];
                    sel_src  = SRC_W'(SRC_FWD0 + i);
                end
            end
        end
    end

    assign accept = in_valid_i & in_ready_q;

    // Next-state for main/skid registers; flush clears occupancy after any
    // same-cycle EX transfer, which needs no extra handling here.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_src_d   = main_src_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_src_d   = skid_src_q;

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no new input can arrive.
            if (out_ready_i) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_src_d   = skid_src_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_ready_i) begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = sel_data;
                main_src_d  = sel_src;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_src_d   = sel_src;
        end

        in_ready_d = ~skid_valid_d;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_src_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_src_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_src_q   <= main_src_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_src_q   <= skid_src_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_o       = main_data_q;
    assign out_src_o   = main_src_q;

endmodule

// File: tb/tb_operand_b_stage.sv
// Self-checking bench for operand_b_stage: directed scenarios followed by
// random traffic, all compared against an in-order queue model.
module tb_operand_b_stage;

    localparam int W  = 32;
    localparam int IW = 16;
    localparam int NF = 2;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    rt_out;
    logic [IW-1:0]   imm;
    logic [1:0]      ext_mode;
    logic            sel;
    logic [NF-1:0]   fwd_en;
    logic [NF*W-1:0] fwd_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out;
    logic [SW-1:0]   out_src;

    int    total = 0;
    int    bad   = 0;
    item_t q[$];
    bit    acc_last;

    operand_b_stage #(
        .WIDTH   (W),
        .IMM_W   (IW),
        .NUM_FWD (NF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rt_out_i    (rt_out),
        .imm_i       (imm),
        .ext_mode_i  (ext_mode),
        .sel_i       (sel),
        .fwd_en_i    (fwd_en),
        .fwd_data_i  (fwd_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out),
        .out_src_o   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference operand choice computed from the selection rules directly.
    function automatic item_t ref_pick();
        item_t r;
        r.d = rt_out;
        r.s = 2'd0;
        if (sel) begin
            r.s = 2'd1;
            if (ext_mode == 2'd1)      r.d = 32'(imm);
            else if (ext_mode == 2'd2) r.d = 32'(imm) << 16;
            else                       r.d = 32'($signed(imm));
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (fwd_en[i]) begin
                    r.d = fwd_data[i*W +: W];
                    r.s = 2'(2 + i);
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("out", out, q[0].d);
            chk("out_src", out_src, q[0].s);
        end
    endtask

    // One clock: model at most two held items in order, then compare.
    task automatic tick();
        item_t it;
        bit    acc;
        bit    pop;
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        it  = ref_pick();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(it);
        end
        acc_last = acc && !flush;
        @(negedge clk);
        check_outputs();
    endtask

    logic [W-1:0] ext_exp [3];
    logic [W-1:0] seen[$];
    logic [W-1:0] abc [3];
    int           drops;

    initial begin
        ext_exp = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
        abc     = '{32'hA0A0, 32'hB0B0, 32'hC0C0};
        rst_n = 1'b0; in_valid = 1'b0; rt_out = '0; imm = '0; ext_mode = '0;
        sel = 1'b0; fwd_en = '0; fwd_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out", out, '0);
        chk("rst_out_src", out_src, '0);

        // Immediate extension modes.
        out_ready = 1'b1;
        sel = 1'b1; imm = 16'h8001; in_valid = 1'b1;
        for (int m = 0; m < 3; m++) begin
            ext_mode = 2'(m);
            tick();
            chk("ext_value", out, ext_exp[m]);
            chk("ext_src", out_src, 2'd1);
        end

        // Forward priority.
        ext_mode = 2'd0; sel = 1'b0; rt_out = 32'h11; fwd_data = {32'hBB, 32'hAA};
        fwd_en = 2'b11; tick();
        chk("fwd0_value", out, 32'hAA);  chk("fwd0_src", out_src, 2'd2);
        fwd_en = 2'b10; tick();
        chk("fwd1_value", out, 32'hBB);  chk("fwd1_src", out_src, 2'd3);
        fwd_en = 2'b00; tick();
        chk("rt_value", out, 32'h11);    chk("rt_src", out_src, 2'd0);
        sel = 1'b1; fwd_en = 2'b11; tick();
        chk("imm_over_fwd", out, 32'hFFFF8001); chk("imm_over_fwd_src", out_src, 2'd1);

        // Back-pressure: A on output, B in skid, C held off.
        sel = 1'b0; fwd_en = '0; in_valid = 1'b0; tick();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rt_out = abc[k];
            tick();
        end
        tick();
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_hold_a", out, abc[0]);
        seen.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen.push_back(out);
            tick();
            if (acc_last) in_valid = 1'b0;
        end
        chk("bp_count", seen.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen.size()) chk("bp_order", seen[k], abc[k]);
        end

        // Flush with two items held and D presented.
        out_ready = 1'b0; in_valid = 1'b1;
        rt_out = 32'hE; tick();
        rt_out = 32'hF; tick();
        rt_out = 32'hD; flush = 1'b1; tick();
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        // Throughput: one item per cycle, in_ready stays high.
        drops = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            rt_out = $urandom; sel = 1'($urandom); imm = 16'($urandom);
            ext_mode = 2'($urandom); fwd_en = 2'($urandom);
            if (!in_ready) drops++;
            tick();
        end
        chk("tp_ready_drops", drops, 0);

        // Asynchronous reset while items are held.
        out_ready = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out", out, '0);
        chk("arst_out_src", out_src, '0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rt_out    = $urandom;
            imm       = 16'($urandom);
            ext_mode  = 2'($urandom);
            sel       = 1'($urandom);
            fwd_en    = 2'($urandom);
            fwd_data  = {$urandom, $urandom};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
